mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_arbiter_if.sv | 35 +++
 rtl/mem_arb_pick.sv | 41 ++++
 rtl/mem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arb_pkg.sv
// Shared widths and types for the two-port memory arbiter.
// Optional round-robin tie-breaking is enabled by defining MEM_ARB_ROUND_ROBIN_EN.
package mem_arb_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    typedef logic port_t;

    localparam port_t PORT0 = 1'b0;
    localparam port_t PORT1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of mem_arbiter; the arbiter uses the slave view,
// the requesters plus memory environment use the master view.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              ack0;
    logic              ack1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic [ADDR_W-1:0] memAddr;
    logic [DATA_W-1:0] memWriteData;
    logic              memWrite;
    logic              memRead;
    logic [DATA_W-1:0] memReadData;
    logic              busy;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
        output ack0, ack1, rdata0, rdata1, memAddr, memWriteData, memWrite, memRead, busy
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, memReadData,
        input  ack0, ack1, rdata0, rdata1, memAddr, memWriteData, memWrite, memRead, busy
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Winner selection for mem_arbiter. With MEM_ARB_ROUND_ROBIN_EN a tie goes to the port
// not served last; otherwise port 0 always wins a tie and 'last' is ignored.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic  req0,
    input  logic  req1,
    input  port_t last,
    output port_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Tie resolved against the most recently served port.
    always_comb begin
        winner = PORT0;
        if (req0 && req1) begin
            winner = (last == PORT0) ? PORT1 : PORT0;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end
`else
    logic unused_last_s;
    assign unused_last_s = last;

    // Fixed priority: port 0 first.
    always_comb begin
        winner = PORT0;
        if (req0) begin
            winner = PORT0;
        end else if (req1) begin
            winner = PORT1;
        end else begin
            winner = PORT0;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port single-memory arbiter: IDLE -> ACCESS -> DONE, one access every 3 cycles.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-breaking (default: port 0 priority).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    state_e            state_q,     state_d;
    port_t             winner_q,    winner_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] rdata0_q,    rdata0_d;
    logic [DATA_W-1:0] rdata1_q,    rdata1_d;
    logic              mem_write_q, mem_write_d;
    logic              mem_read_q,  mem_read_d;
    logic              ack0_q,      ack0_d;
    logic              ack1_q,      ack1_d;
    logic              busy_q,      busy_d;

    port_t             pick_s;
    port_t             last_s;
    logic              sel_we_s;
    logic [ADDR_W-1:0] sel_addr_s;
    logic [DATA_W-1:0] sel_wdata_s;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    port_t last_q, last_d;

    // The port just completing its access becomes the most recently served one.
    always_comb begin
        last_d = last_q;
        if (state_q == ACCESS) begin
            last_d = winner_q;
        end else begin
            last_d = last_q;
        end
    end

    // Last-served register; after reset port 0 is favoured on a tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= PORT1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_s = last_q;
`else
    assign last_s = PORT1;
`endif

    mem_arb_pick u_pick (
        .req0   (bus.req0),
        .req1   (bus.req1),
        .last   (last_s),
        .winner (pick_s)
    );

    // Route the chosen requester's command towards the latch.
    always_comb begin
        sel_we_s    = bus.we0;
        sel_addr_s  = bus.addr0;
        sel_wdata_s = bus.wdata0;
        if (pick_s == PORT1) begin
            sel_we_s    = bus.we1;
            sel_addr_s  = bus.addr1;
            sel_wdata_s = bus.wdata1;
        end else begin
            sel_we_s    = bus.we0;
            sel_addr_s  = bus.addr0;
            sel_wdata_s = bus.wdata0;
        end
    end

    // Next state and next output-register values; strobes and acks default low.
    always_comb begin
        state_d     = state_q;
        winner_d    = winner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        mem_write_d = 1'b0;
        mem_read_d  = 1'b0;
        ack0_d      = 1'b0;
        ack1_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    winner_d    = pick_s;
                    mem_addr_d  = sel_addr_s;
                    mem_wdata_d = sel_wdata_s;
                    mem_write_d = sel_we_s;
                    mem_read_d  = !sel_we_s;
                    state_d     = ACCESS;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                state_d = DONE;
                // mem_read_q doubles as the latched "this is a read" flag.
                if (winner_q == PORT1) begin
                    ack1_d = 1'b1;
                    if (mem_read_q) begin
                        rdata1_d = bus.memReadData;
                    end else begin
                        rdata1_d = rdata1_q;
                    end
                end else begin
                    ack0_d = 1'b1;
                    if (mem_read_q) begin
                        rdata0_d = bus.memReadData;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            winner_q    <= PORT0;
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            rdata0_q    <= {DATA_W{1'b0}};
            rdata1_q    <= {DATA_W{1'b0}};
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            winner_q    <= winner_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rdata0_q    <= rdata0_d;
            rdata1_q    <= rdata1_d;
            mem_write_q <= mem_write_d;
            mem_read_q  <= mem_read_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.memAddr      = mem_addr_q;
    assign bus.memWriteData = mem_wdata_q;
    assign bus.memWrite     = mem_write_q;
    assign bus.memRead      = mem_read_q;
    assign bus.ack0         = ack0_q;
    assign bus.ack1         = ack1_q;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.busy         = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cases with literal expectations, then randomized
// two-port traffic compared every cycle against a transaction-level model.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;

    mem_arbiter_if bus ();

    mem_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Requester state, mirrored onto the interface
    logic        req_a  [2];
    logic        we_a   [2];
    logic [12:0] addr_a [2];
    logic [7:0]  wd_a   [2];

    assign bus.req0   = req_a[0];
    assign bus.req1   = req_a[1];
    assign bus.we0    = we_a[0];
    assign bus.we1    = we_a[1];
    assign bus.addr0  = addr_a[0];
    assign bus.addr1  = addr_a[1];
    assign bus.wdata0 = wd_a[0];
    assign bus.wdata1 = wd_a[1];

    // Memory seen by the DUT, and the reference copy owned by the model
    logic [7:0] mem     [0:8191];
    logic [7:0] ref_mem [0:8191];

    assign bus.memReadData = mem[bus.memAddr];

    initial forever begin
        @(posedge clk);
        if (bus.memWrite) mem[bus.memAddr] = bus.memWriteData;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // A grant at edge g means: memory op between g and g+1, ack between g+1 and g+2,
    // next grant possible at g+3.
    int          k         = 0;
    int          g_edge    = -100;
    int          free_edge = 0;
    int          l_w       = 0;
    int          last_w    = 1;
    logic        l_we      = 1'b0;
    logic [12:0] l_addr    = 13'd0;
    logic [7:0]  l_wd      = 8'd0;

    logic        exp_ack0 = 1'b0, exp_ack1 = 1'b0, exp_mw = 1'b0, exp_mr = 1'b0, exp_busy = 1'b0;
    logic [7:0]  exp_rd0  = 8'd0, exp_rd1 = 8'd0, exp_wd = 8'd0;
    logic [12:0] exp_addr = 13'd0;

    initial forever begin
        @(posedge clk or posedge rst);
        k++;
        exp_ack0 = 1'b0; exp_ack1 = 1'b0; exp_mw = 1'b0; exp_mr = 1'b0; exp_busy = 1'b0;
        if (rst) begin
            exp_rd0 = 8'd0; exp_rd1 = 8'd0; exp_addr = 13'd0; exp_wd = 8'd0;
            g_edge = -100; free_edge = 0; last_w = 1;
        end else if (k == g_edge + 1) begin
            if (l_we) ref_mem[l_addr] = l_wd;
            else if (l_w == 0) exp_rd0 = ref_mem[l_addr];
            else exp_rd1 = ref_mem[l_addr];
            if (l_w == 0) exp_ack0 = 1'b1;
            else exp_ack1 = 1'b1;
            exp_busy = 1'b1;
            last_w = l_w;
        end else if (k >= free_edge && (bus.req0 || bus.req1)) begin
            if (bus.req0 && bus.req1) l_w = RR ? (1 - last_w) : 0;
            else l_w = bus.req0 ? 0 : 1;
            l_we   = (l_w == 0) ? bus.we0 : bus.we1;
            l_addr = (l_w == 0) ? bus.addr0 : bus.addr1;
            l_wd   = (l_w == 0) ? bus.wdata0 : bus.wdata1;
            g_edge = k; free_edge = k + 3;
            exp_addr = l_addr; exp_wd = l_wd;
            exp_mw = l_we; exp_mr = !l_we; exp_busy = 1'b1;
        end
    end

    // Per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        chk("ack0",         bus.ack0,         exp_ack0);
        chk("ack1",         bus.ack1,         exp_ack1);
        chk("rdata0",       bus.rdata0,       exp_rd0);
        chk("rdata1",       bus.rdata1,       exp_rd1);
        chk("memAddr",      bus.memAddr,      exp_addr);
        chk("memWriteData", bus.memWriteData, exp_wd);
        chk("memWrite",     bus.memWrite,     exp_mw);
        chk("memRead",      bus.memRead,      exp_mr);
        chk("busy",         bus.busy,         exp_busy);
    end

    // ---------------- stimulus helpers ----------------
    task automatic preload(input logic [12:0] a, input logic [7:0] d);
        mem[a]     = d;
        ref_mem[a] = d;
    endtask

    task automatic single(input int p, input logic we, input logic [12:0] a,
                          input logic [7:0] d, input logic [7:0] exp_rd, input logic glitch);
        @(posedge clk); #1;
        req_a[p] = 1'b1; we_a[p] = we; addr_a[p] = a; wd_a[p] = d;
        @(negedge clk);
        chk("pre_grant_strobes", {bus.memWrite, bus.memRead}, 2'b00);
        @(negedge clk);
        chk("acc_write", bus.memWrite, we);
        chk("acc_read",  bus.memRead,  !we);
        chk("acc_addr",  bus.memAddr,  a);
        if (we) chk("acc_wdata", bus.memWriteData, d);
        if (glitch) begin
            addr_a[p] = a ^ 13'h0155;
            wd_a[p]   = ~d;
            #1 chk("glitch_addr", bus.memAddr, a);
        end
        @(negedge clk);
        chk("done_ack",       (p == 0) ? bus.ack0 : bus.ack1, 1'b1);
        chk("done_other_ack", (p == 0) ? bus.ack1 : bus.ack0, 1'b0);
        if (!we) chk("done_rdata", (p == 0) ? bus.rdata0 : bus.rdata1, exp_rd);
        chk("done_strobes", {bus.memWrite, bus.memRead}, 2'b00);
        @(posedge clk); #1;
        req_a[p] = 1'b0;
    endtask

    task automatic drive_port(input int p);
        logic in_svc;
        logic done_now;
        in_svc   = ((k == g_edge) || (k == g_edge + 1)) && (l_w == p);
        done_now = (k == g_edge + 2) && (l_w == p);
        if (done_now && req_a[p]) begin
            req_a[p] = 1'b0;
        end else if (req_a[p] && in_svc) begin
            if ($urandom_range(0, 3) == 0) begin
                addr_a[p] = 13'($urandom);
                wd_a[p]   = 8'($urandom);
                we_a[p]   = 1'($urandom_range(0, 1));
            end
        end else if (req_a[p]) begin
            if ($urandom_range(0, 15) == 0) req_a[p] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
            req_a[p]  = 1'b1;
            we_a[p]   = 1'($urandom_range(0, 1));
            addr_a[p] = ($urandom_range(0, 3) == 0) ? 13'($urandom) : 13'($urandom_range(0, 15));
            wd_a[p]   = 8'($urandom);
        end
    endtask

    int seq [6];
    int at  [6];
    int n_acks;

    initial begin
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'(i * 13 + 5);
            ref_mem[i] = 8'(i * 13 + 5);
        end
        for (int p = 0; p < 2; p++) begin
            req_a[p] = 1'b0; we_a[p] = 1'b0; addr_a[p] = 13'd0; wd_a[p] = 8'd0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset values
        @(negedge clk);
        chk("rst_ack0",    bus.ack0,         1'b0);
        chk("rst_ack1",    bus.ack1,         1'b0);
        chk("rst_rdata0",  bus.rdata0,       8'h00);
        chk("rst_rdata1",  bus.rdata1,       8'h00);
        chk("rst_memAddr", bus.memAddr,      13'd0);
        chk("rst_memWD",   bus.memWriteData, 8'h00);
        chk("rst_strobes", {bus.memWrite, bus.memRead}, 2'b00);
        chk("rst_busy",    bus.busy,         1'b0);

        // Single read, write-then-read on port 1, address glitch during ACCESS
        preload(13'd1000, 8'h01);
        single(0, 1'b0, 13'd1000, 8'h00, 8'h01, 1'b0);
        single(1, 1'b1, 13'd5,    8'h07, 8'h00, 1'b0);
        single(1, 1'b0, 13'd5,    8'h00, 8'h07, 1'b0);
        chk("wr_mem5", mem[5], 8'h07);
        preload(13'd200, 8'h3C);
        single(0, 1'b0, 13'd200,  8'h00, 8'h3C, 1'b1);

        // Contention from a fresh reset with both requests held
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_a[0] = 1'b1; we_a[0] = 1'b0; addr_a[0] = 13'd10;
        req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = 13'd11;
        n_acks = 0;
        for (int c = 0; c < 30 && n_acks < 6; c++) begin
            @(negedge clk);
            if (bus.ack0 || bus.ack1) begin
                seq[n_acks] = bus.ack1 ? 1 : 0;
                at[n_acks]  = c;
                n_acks++;
            end
        end
        chk("cont_count", n_acks, 6);
        for (int i = 0; i < n_acks; i++) begin
            chk("cont_winner", seq[i], RR ? (i % 2) : 0);
            if (i > 0) chk("cont_gap", at[i] - at[i-1], 3);
        end
        @(posedge clk); #1;
        req_a[0] = 1'b0; req_a[1] = 1'b0;
        repeat (4) @(posedge clk);

        // Reset during a write ACCESS
        preload(13'd77, 8'h5A);
        #1;
        req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = 13'd77; wd_a[1] = 8'hC3;
        @(negedge clk);
        @(negedge clk);
        chk("rst_acc_pre_mw", bus.memWrite, 1'b1);
        #2 rst = 1'b1;
        req_a[1] = 1'b0;
        #1;
        chk("rst_acc_mw",   bus.memWrite, 1'b0);
        chk("rst_acc_busy", bus.busy,     1'b0);
        chk("rst_acc_ack",  bus.ack1,     1'b0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("rst_acc_noack", {bus.ack0, bus.ack1}, 2'b00);
        end
        chk("rst_acc_mem", mem[77], 8'h5A);

        // Randomized traffic
        repeat (3000) begin
            @(posedge clk); #1;
            drive_port(0);
            drive_port(1);
        end
        @(posedge clk); #1;
        req_a[0] = 1'b0; req_a[1] = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
